// File: rtl/sram_controller.sv
// sram_controller
// ---------------
// Responder end of the MEM-stage memory interface. A single 32-bit load or
// store from the pipeline is served as two 16-bit accesses to the external
// asynchronous SRAM: low half-word first, then high half-word. Each half-word
// phase lasts WAIT_CYCLES+1 clock cycles. A one-cycle DONE state follows,
// during which ready is high. The pipeline uses ~ready as its MEM freeze.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   wr_en, rd_en  - store / load request (store wins when both are high)
//   address       - pipeline byte address; BASE_ADDR maps to half-word 0
//   write_data    - store data
//   read_data     - registered load data; holds its value between loads
//   ready         - high when idle with no request, or in the DONE cycle
//   sram_addr     - SRAM half-word address
//   sram_dq       - bidirectional SRAM data bus
//   sram_*_n      - active-low SRAM strobes (we, oe, ce, ub, lb)
//
// Optional feature (macro SRAM_STATS_EN):
//   read_count, write_count - 16-bit wrapping counts of completed accesses

module sram_controller #(
  parameter int ADDRESS_LEN   = 32,
  parameter int DATA_LEN      = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16,
  parameter int BASE_ADDR     = 1024,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDRESS_LEN-1:0]   address,
  input  logic [DATA_LEN-1:0]      write_data,
  output logic [DATA_LEN-1:0]      read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  inout  wire  [SRAM_DATA_LEN-1:0] sram_dq,
  output logic                     sram_we_n,
  output logic                     sram_oe_n,
  output logic                     sram_ce_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n
`ifdef SRAM_STATS_EN
  ,
  output logic [15:0]              read_count,
  output logic [15:0]              write_count
`endif
);

  localparam int PHASE_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [PHASE_W-1:0]       phase_cnt;
  logic [SRAM_ADDR_LEN-2:0] word_q;
  logic [DATA_LEN-1:0]      wdata_q;
  logic                     is_write_q;
  logic                     phase_last;
  logic                     request;
  logic [ADDRESS_LEN-1:0]   offset;
  logic                     drive_en;
  logic [SRAM_DATA_LEN-1:0] drive_val;
  logic                     unused_offset_bits;

  assign request    = wr_en | rd_en;
  assign phase_last = (phase_cnt == PHASE_LAST);

  // Byte offset from the SRAM window base; bits [1:0] select a byte inside
  // the word and are dropped, the top bits fall outside the SRAM and wrap.
  assign offset = address - ADDRESS_LEN'(BASE_ADDR);
  assign unused_offset_bits = ^{offset[ADDRESS_LEN-1:SRAM_ADDR_LEN+1], offset[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Request latch, phase counter and load-data capture. The SRAM data is
  // sampled on the last cycle of each phase so it has had the full phase
  // to settle after the address change.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt  <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      read_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          if (request) begin
            word_q     <= offset[SRAM_ADDR_LEN:2];
            wdata_q    <= write_data;
            is_write_q <= wr_en;
          end
        end
        LOW: begin
          phase_cnt <= phase_last ? '0 : phase_cnt + 1'b1;
          if (!is_write_q && phase_last)
            read_data[SRAM_DATA_LEN-1:0] <= sram_dq;
        end
        HIGH: begin
          phase_cnt <= phase_last ? '0 : phase_cnt + 1'b1;
          if (!is_write_q && phase_last)
            read_data[2*SRAM_DATA_LEN-1:SRAM_DATA_LEN] <= sram_dq;
        end
        default: phase_cnt <= '0;
      endcase
    end
  end

  // Next-state logic and SRAM strobes. Strobes are inactive and the address
  // is parked at zero outside the two half-word phases.
  always_comb begin
    next_state = state;
    sram_addr  = '0;
    sram_ce_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    drive_en   = 1'b0;
    drive_val  = '0;
    case (state)
      IDLE: begin
        if (request) next_state = LOW;
      end
      LOW: begin
        sram_addr = {word_q, 1'b0};
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_we_n = ~is_write_q;
        sram_oe_n = is_write_q;
        drive_en  = is_write_q;
        drive_val = wdata_q[SRAM_DATA_LEN-1:0];
        if (phase_last) next_state = HIGH;
      end
      HIGH: begin
        sram_addr = {word_q, 1'b1};
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_we_n = ~is_write_q;
        sram_oe_n = is_write_q;
        drive_en  = is_write_q;
        drive_val = wdata_q[2*SRAM_DATA_LEN-1:SRAM_DATA_LEN];
        if (phase_last) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The bus is only driven while writing; otherwise the SRAM owns it.
  assign sram_dq = drive_en ? drive_val : {SRAM_DATA_LEN{1'bz}};

  assign ready = ((state == IDLE) && !request) || (state == DONE);

`ifdef SRAM_STATS_EN
  // Completed-access counters; only DONE counts, so aborted accesses never do.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (state == DONE) begin
      if (is_write_q) write_count <= write_count + 16'd1;
      else            read_count  <= read_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// ------------------
// Drives directed and random load/store requests into sram_controller,
// models the external SRAM, and compares every observable against a
// half-word-addressed reference memory and the documented cycle timing.

module tb_sram_controller;

  localparam int W       = 1;
  localparam int BASE    = 1024;
  localparam int LAT     = 2 * (W + 1) + 1;
  localparam int MEM_SZ  = 262144;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_STATS_EN
  logic [15:0] read_count, write_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [15:0] ref_half [int];
  logic [31:0] ref_read_data = 32'd0;
  int          exp_reads  = 0;
  int          exp_writes = 0;

  // External SRAM model
  logic [15:0] mem [0:MEM_SZ-1];
  int          wr_hold = 0;
  logic [17:0] wr_addr_prev = 18'd0;

  sram_controller #(
    .ADDRESS_LEN(32), .DATA_LEN(32), .SRAM_ADDR_LEN(18), .SRAM_DATA_LEN(16),
    .BASE_ADDR(BASE), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq(sram_dq),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
`ifdef SRAM_STATS_EN
    ,
    .read_count(read_count),
    .write_count(write_count)
`endif
  );

  always #5 clk = ~clk;

  // SRAM drives the bus only for a read strobe.
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  // A write only takes effect once we_n has been held low at a stable
  // address for the full write-cycle time (W+1 clock edges).
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (wr_hold > 0 && sram_addr == wr_addr_prev) begin
        wr_hold <= wr_hold + 1;
        if (wr_hold + 1 == W + 1) mem[sram_addr] <= sram_dq;
      end else begin
        wr_hold <= 1;
        if (W == 0) mem[sram_addr] <= sram_dq;
      end
      wr_addr_prev <= sram_addr;
    end else begin
      wr_hold <= 0;
    end
  end

  function automatic logic [15:0] refGet(input int idx);
    return ref_half.exists(idx) ? ref_half[idx] : 16'h0000;
  endfunction

  function automatic int wordOf(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'(BASE);
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request, held until the DONE cycle, with per-cycle checks
  // of ready and the SRAM strobes, then checks of the load data and of the
  // SRAM contents. Entered and left just after a rising edge.
  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [31:0] addr, input logic [31:0] data);
    int          w;
    logic        is_wr;
    logic [31:0] exp_rd;
    logic        in_phase;
    logic        upper;
    w     = wordOf(addr);
    is_wr = wr;
    if (is_wr) begin
      ref_half[2*w]     = data[15:0];
      ref_half[2*w + 1] = data[31:16];
      exp_writes++;
    end else begin
      ref_read_data = {refGet(2*w + 1), refGet(2*w)};
      exp_reads++;
    end
    exp_rd = ref_read_data;

    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      in_phase = (c >= 1) && (c <= 2 * (W + 1));
      upper    = (c > W + 1);
      checkOutput($sformatf("ready_c%0d", c), {31'd0, ready}, {31'd0, c == LAT});
      checkOutput($sformatf("ce_n_c%0d", c), {31'd0, sram_ce_n}, {31'd0, !in_phase});
      checkOutput($sformatf("we_n_c%0d", c), {31'd0, sram_we_n}, {31'd0, !(in_phase && is_wr)});
      checkOutput($sformatf("oe_n_c%0d", c), {31'd0, sram_oe_n}, {31'd0, !(in_phase && !is_wr)});
      checkOutput($sformatf("ub_lb_n_c%0d", c), {30'd0, sram_ub_n, sram_lb_n},
                  in_phase ? 32'd0 : 32'd3);
      checkOutput($sformatf("sram_addr_c%0d", c), {14'd0, sram_addr},
                  in_phase ? 32'((2 * w) + (upper ? 1 : 0)) : 32'd0);
      if (c == LAT) checkOutput("read_data_done", read_data, exp_rd);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (is_wr) begin
      checkOutput("sram_lo_half", {16'd0, mem[2*w]}, {16'd0, data[15:0]});
      checkOutput("sram_hi_half", {16'd0, mem[2*w + 1]}, {16'd0, data[31:16]});
    end
  endtask

  initial begin
    logic [15:0] prev9;
    int          op;
    logic [31:0] ra;

    for (int i = 0; i < MEM_SZ; i++) mem[i] = 16'h0000;

    // Reset, then idle with no requests.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_ready", {31'd0, ready}, 32'd1);
      checkOutput("idle_strobes", {27'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n},
                  32'h1F);
      checkOutput("idle_addr", {14'd0, sram_addr}, 32'd0);
      checkOutput("idle_read_data", read_data, 32'd0);
    end
    @(posedge clk);
    #1;

    // Directed cases.
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'h12345678);
    checkOutput("both_read_data_kept", read_data, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'd1035, 32'h0);

    // Reset during the first HIGH cycle of a store to 1040 (half-words 8/9).
    prev9      = refGet(9);
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort_in_high_addr", {14'd0, sram_addr}, 32'd9);
    rst   = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", {31'd0, ready}, 32'd1);
    checkOutput("abort_strobes", {27'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n},
                32'h1F);
    checkOutput("abort_addr", {14'd0, sram_addr}, 32'd0);
    checkOutput("abort_read_data", read_data, 32'd0);
    checkOutput("abort_lo_written", {16'd0, mem[8]}, 32'h0000F00D);
    checkOutput("abort_hi_untouched", {16'd0, mem[9]}, {16'd0, prev9});
    ref_half[8]   = 16'hF00D;
    ref_read_data = 32'd0;
`ifdef SRAM_STATS_EN
    // Reset clears the counters; the aborted store is not counted.
    exp_reads  = 0;
    exp_writes = 0;
`endif
    @(posedge clk);
    #1;

    // Random mix over a small window so loads hit earlier stores.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 2));
      ra = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      applyStimulus(op != 1, op != 0, ra, $urandom);
    end

`ifdef SRAM_STATS_EN
    checkOutput("write_count", {16'd0, write_count}, 32'(exp_writes & 32'hFFFF));
    checkOutput("read_count", {16'd0, read_count}, 32'(exp_reads & 32'hFFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder end of the MEM-stage memory interface.
- Accepts single-word 32-bit read/write requests from the pipeline and serves each as two 16-bit accesses to the external SRAM.
- Holds `ready` low while an access is in progress; the pipeline derives `freeze_MEM = ~ready` from it.
- Sits between MEM_Stage and the board SRAM pins.

Parameters:
- ADDRESS_LEN, 32, width of the pipeline byte address
- DATA_LEN, 32, width of the pipeline data word
- SRAM_ADDR_LEN, 18, width of the SRAM half-word address
- SRAM_DATA_LEN, 16, width of the SRAM data bus
- BASE_ADDR, 1024, pipeline byte address that maps to SRAM half-word 0
- WAIT_CYCLES, 1, extra cycles each half-word phase is held (phase length = WAIT_CYCLES+1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request from MEM stage
- rd_en  in  1  read request from MEM stage
- address  in  ADDRESS_LEN  byte address (ALU result)
- write_data  in  DATA_LEN  store data (Rm value)
- read_data  out  DATA_LEN  load data, registered
- ready  out  1  high = no access pending or access complete this cycle
- sram_addr  out  SRAM_ADDR_LEN  SRAM half-word address
- sram_dq  inout  SRAM_DATA_LEN  SRAM data bus
- sram_we_n  out  1  SRAM write enable, active low
- sram_oe_n  out  1  SRAM output enable, active low
- sram_ce_n  out  1  SRAM chip enable, active low
- sram_ub_n  out  1  SRAM upper-byte enable, active low
- sram_lb_n  out  1  SRAM lower-byte enable, active low

Behaviour:
- States: IDLE, LOW, HIGH, DONE. A phase counter counts 0..WAIT_CYCLES within LOW and HIGH.
- Request latch: in IDLE, if `wr_en | rd_en`, latch `address`, `write_data` and the operation, then go to LOW.
  - `wr_en` has priority when both are high.
  - Requester holds inputs stable until it sees `ready` = 1; latched copies are used regardless.
- Address mapping: `word = (address - BASE_ADDR) >> 2`, truncated to SRAM_ADDR_LEN-1 bits.
  - LOW phase: `sram_addr = {word, 1'b0}`.
  - HIGH phase: `sram_addr = {word, 1'b1}`.
  - Address bits [1:0] are ignored.
- LOW and HIGH each last WAIT_CYCLES+1 cycles. LOW goes to HIGH, and HIGH goes to DONE, when the phase count equals WAIT_CYCLES.
- During LOW and HIGH:
  - `ce_n` = 0, `ub_n` = 0, `lb_n` = 0.
  - Write: `we_n` = 0, `oe_n` = 1, `sram_dq` driven with `write_data[15:0]` (LOW) or `write_data[31:16]` (HIGH).
  - Read: `we_n` = 1, `oe_n` = 0, `sram_dq` = Z. `sram_dq` is captured into `read_data[15:0]` / `read_data[31:16]` on the last cycle of LOW / HIGH.
- DONE: lasts 1 cycle. SRAM controls are inactive and `ready` = 1. Next state is IDLE unconditionally.
- IDLE, DONE and reset: `ce_n` = `oe_n` = `we_n` = `ub_n` = `lb_n` = 1, `sram_dq` = Z, `sram_addr` = 0.
- `ready` is combinational: `ready = (state==IDLE & ~wr_en & ~rd_en) | (state==DONE)`.
- Latency: cycle 0 is the first IDLE cycle with a request. `ready` = 0 for cycles 0..2·(WAIT_CYCLES+1), and `ready` = 1 in cycle 2·(WAIT_CYCLES+1)+1 (cycle 5 for WAIT_CYCLES=1).
- A request still asserted in the IDLE cycle after DONE starts a new access; back-to-back requests are allowed.
- `read_data`:
  - Reset value 0.
  - Holds its last value between reads.
  - Unchanged by writes.
  - Valid from the DONE cycle onward.
- Reset mid-access: next state is IDLE, all SRAM controls are inactive, the bus is released, `read_data` = 0, and the partial access is abandoned. A half-word already written stays written.
- Reset value of `ready` is 1 when no request is present.

Optional Feature:
- Macro: SRAM_STATS_EN.
- With the macro defined:
  - Adds outputs `read_count[15:0]` and `write_count[15:0]`.
  - Each counter increments once per completed access, in the DONE cycle.
  - Counters wrap 0xFFFF→0 and reset to 0.
  - Aborted accesses are not counted.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Idle: no request for 10 cycles -> `ready` = 1, all `*_n` = 1, `sram_dq` = Z, `read_data` = 0.
- Write `wr_en`=1, `address`=1024, `write_data`=0xDEADBEEF, WAIT_CYCLES=1 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; `ready` = 0 in cycles 0–4 and `ready` = 1 in cycle 5.
- Read `rd_en`=1, `address`=1024 after the previous write -> `read_data` = 0xDEADBEEF in cycle 5; `we_n` stays 1 throughout.
- `wr_en`=`rd_en`=1, `address`=1032, `write_data`=0x12345678 -> write performed: SRAM[4]=0x5678, SRAM[5]=0x1234; `read_data` unchanged.
- `rst` asserted in the first HIGH cycle of a write of 0xCAFEF00D to 1040 -> next cycle IDLE, `we_n` = 1, bus Z; SRAM[8]=0xF00D, SRAM[9] unchanged; `read_data` = 0.
- SRAM_STATS_EN: 3 writes then 2 reads completed -> `write_count` = 3, `read_count` = 2. Preload `write_count` = 0xFFFF then one write -> `write_count` = 0.
